// File: rtl/decoder_rr_arbiter_if.sv
// Bundle between the round-robin arbiter and its user: requests/release in,
// decoder select (index + enable) and one-hot grant out.
interface decoder_rr_arbiter_if;
    // Handshake: req_i[n] is a level held by requester n until it is granted or
    // withdraws. gnt_valid_o/dec_en_o high means gnt_idx_o owns the decoder; the
    // owner ends its turn by pulsing release_i (ignored when no grant is active).
    logic [7:0] req_i;
    logic       release_i;
    logic       gnt_valid_o;
    logic [2:0] gnt_idx_o;
    logic       dec_en_o;
    logic [7:0] gnt_onehot_o;
    logic       timeout_o;
    logic       dbg_grant_o;

    modport master (
        output req_i, release_i,
        input  gnt_valid_o, gnt_idx_o, dec_en_o, gnt_onehot_o, timeout_o, dbg_grant_o
    );

    modport slave (
        input  req_i, release_i,
        output gnt_valid_o, gnt_idx_o, dec_en_o, gnt_onehot_o, timeout_o, dbg_grant_o
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// 8-way round-robin arbiter driving a 3-to-8 decoder select with a forced idle
// bubble between owners. Optional forced release after MAX_HOLD: ARB_TIMEOUT_EN.
module decoder_rr_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input logic                  clk,
    input logic                  rst_n,
    decoder_rr_arbiter_if.slave  bus
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic       en_q, en_d;
    logic [7:0] oh_q, oh_d;

    logic [14:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  win_off;
    logic [2:0]  winner;
    logic        any_req;
    logic        hold_expired;
    logic        end_grant;

    if (2**CNT_W <= MAX_HOLD) begin : g_cnt_w_check
        $error("CNT_W too narrow for MAX_HOLD");
    end

    // Rotating by ptr turns the round-robin search into a plain lowest-bit search.
    assign req_dbl = {bus.req_i[6:0], bus.req_i};
    assign req_rot = req_dbl[{1'b0, ptr_q} +: 8];
    assign any_req = |bus.req_i;
    assign winner  = ptr_q + win_off;

    always_comb begin
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) win_off = 3'(i);
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    assign hold_expired = (cnt_q == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        cnt_d = (state_q == S_GRANT) ? cnt_q + CNT_W'(1) : '0;
        // Release or withdrawal in the expiring cycle counts as a normal end.
        to_d  = (state_q == S_GRANT) && hold_expired && !bus.release_i && bus.req_i[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign bus.timeout_o = to_q;
`else
    assign hold_expired  = 1'b0;
    assign bus.timeout_o = 1'b0;
`endif

    assign end_grant = bus.release_i || !bus.req_i[idx_q] || hold_expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= 3'd0;
            idx_q   <= 3'd0;
            en_q    <= 1'b0;
            oh_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            oh_q    <= oh_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req)   state_d = S_GRANT;
            S_GRANT: if (end_grant) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the bubble falls out of IDLE lasting one cycle.
    always_comb begin
        idx_d = idx_q;
        ptr_d = ptr_q;
        if (state_q == S_IDLE && any_req) begin
            idx_d = winner;
            ptr_d = winner + 3'd1;
        end
        en_d = (state_d == S_GRANT);
        oh_d = en_d ? (8'h01 << idx_d) : 8'h00;
    end

    assign bus.gnt_valid_o  = en_q;
    assign bus.dec_en_o     = en_q;
    assign bus.gnt_idx_o    = idx_q;
    assign bus.gnt_onehot_o = oh_q;
    assign bus.dbg_grant_o  = (state_q == S_GRANT);

endmodule
